win_banner_anim: RTL
====================

Name: win_banner_anim

Overview:
- Animated, parametrised win screen for the game's display pipeline. Draws "P<tally> WON!" using stroke rectangles.
- The player number is shown as 1..NUM_PLAYERS vertical tally bars.
- Sequence: the banner slides up into place, blinks for a fixed number of frames, then holds steady and flags done.
- Pixel output is registered with a fixed 2-cycle latency. It feeds the top-level screen mux alongside the game renderer.

Parameters:
NUM_PLAYERS, 4, number of players (2..8); sets the maximum tally-bar count.
WINNER_W, 3, width of the winner index port.
TEXT_COLOR, 24'hFF_FF_FF, colour of glyph pixels.
BACKGROUND, 24'h00_64_00, colour of non-glyph pixels.
START_X, 11'd64, left edge of the "P" glyph at rest.
START_Y, 11'd128, top edge of the text at rest.
LETTER_WIDTH, 11'd64, glyph width.
LETTER_HEIGHT, 11'd128, glyph height.
LINE_WIDTH, 11'd16, stroke thickness.
LETTER_SPACE, 11'd32, gap between letters; also the tally-bar pitch.
WORD_SPACE, 11'd64, gap between the tally bars and "WON!".
SLIDE_DIST, 11'd256, initial downward offset of the text.
SLIDE_STEP, 11'd16, offset decrement per frame.
BLINK_FRAMES, 8, frames per blink half-period.
HOLD_FRAMES, 64, total frames spent in BLINK.

Ports:
clk  in  1  system pixel clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches winner and starts the animation
winner  in  WINNER_W  0-based winning player index
frame_tick  in  1  one-cycle pulse once per frame (vblank)
hcount  in  11  current pixel x
vcount  in  11  current pixel y
pixel  out  24  RGB output, 2 cycles after hcount/vcount
busy  out  1  high in SLIDE and BLINK
done  out  1  high in DONE

Behaviour:
- Reset is asynchronous, active-low:
  - Outputs: pixel=0, busy=0, done=0.
  - Internal: state=IDLE, y_off=0, visible=0, win_idx=0, counters=0, both pipeline stages cleared.
  - Reset mid-animation aborts to IDLE with no completion pulse.
- States and transitions:
  - IDLE: text hidden, pixel=BACKGROUND. On start: win_idx=min(winner, NUM_PLAYERS-1), y_off=SLIDE_DIST, visible=1, go to SLIDE.
  - SLIDE: on each frame_tick, y_off = (y_off<=SLIDE_STEP) ? 0 : y_off-SLIDE_STEP. On the tick that makes y_off 0, go to BLINK with frame_cnt=0, blink_cnt=0, visible=1.
  - BLINK: on each frame_tick, frame_cnt++ and blink_cnt++. When blink_cnt reaches BLINK_FRAMES, blink_cnt=0 and visible toggles. When frame_cnt reaches HOLD_FRAMES, go to DONE with visible=1.
  - DONE: text steady, done=1. start restarts exactly as from IDLE.
- start is ignored in SLIDE and BLINK.
- start and frame_tick in the same cycle in IDLE/DONE: start wins and the tick is ignored.
- frame_tick in IDLE/DONE has no effect.
- busy and done are registered from state, so they update the cycle after the transition.
- Geometry (all x/y absolute; ty = START_Y + y_off; 11-bit; every rect is inclusive on all four edges):
  - P at START_X: stem (0,0,LW,LH); top bar (LW,0,32,LW); mid bar (LW,48,32,LW); right bar (48,0,LW,64).
  - Tally: NUM_X = START_X+LETTER_WIDTH+LETTER_SPACE. Bar i (i=0..win_idx) is at x = NUM_X + i*LETTER_SPACE, width LW, height LH.
  - W_X = NUM_X + (NUM_PLAYERS-1)*LETTER_SPACE + LW + WORD_SPACE.
  - W: verticals at +0, +32, +64 (height LH); bottom bar at y+112 (width LETTER_WIDTH).
  - O: verticals at +0 and +48; bars at y+0 and y+112.
  - N: verticals at +0 and +48; top bar.
  - "!": stem LW x 80. Each following letter is at previous + LETTER_WIDTH + LETTER_SPACE.
  - Pixels with vcount beyond 11 bits are not drawn; there is no wrap-around artefact because ty <= START_Y+SLIDE_DIST < 2048.
- Pipeline:
  - Stage 1 registers hcount/vcount together with a snapshot of y_off, visible and win_idx, all sampled in the same cycle.
  - Stage 2 computes hit = OR of all rect hits. pixel <= (hit && visible && state!=IDLE) ? TEXT_COLOR : BACKGROUND.
  - Overlapping strokes never sum colours; hits are OR-combined.
  - Latency is exactly 2 clk from hcount/vcount to pixel.

Test Plan:
- Reset: hold reset_n=0 -> pixel=0, busy=0, done=0. Release, drive (64,128) -> pixel=24'h006400 two clocks later (IDLE).
- start with winner=1, one frame_tick -> y_off=240 and busy=1. Pixel at (64,368) is FFFFFF; at (64,367) is 006400. After tick 16 the state is BLINK and (64,128) is FFFFFF.
- Tally with NUM_PLAYERS=4, winner=2 -> bars at x=160,192,224 (FFFFFF); x=256 at y=150 is 006400. With winner=7, clamped -> a 4th bar appears at x=256.
- Blink: during BLINK ticks 0-7, (64,130) is FFFFFF; ticks 8-15 it is 006400. After tick 64: done=1, busy=0, (64,130) is FFFFFF steady.
- start pulsed mid-SLIDE -> y_off sequence unchanged. start in DONE -> y_off=256, busy=1. reset_n low mid-BLINK -> IDLE immediately; pixel=0 while reset is held, then BACKGROUND.
- Latency: step hcount 63->64 at y=128 in DONE -> pixel switches 006400->FFFFFF exactly 2 clk later. start+frame_tick in the same cycle in IDLE -> y_off=256, not 240.

Source files
------------

// File: rtl/win_banner_anim.sv
`default_nettype none
// ==========================================================================
// win_banner_anim : animated "P<tally> WON!" win screen, 2-cycle pixel path
// Rev 1.0
// ==========================================================================
module win_banner_anim #(
   parameter int          NUM_PLAYERS   = 4,
   parameter int          WINNER_W      = 3,
   parameter logic [23:0] TEXT_COLOR    = 24'hFF_FF_FF,
   parameter logic [23:0] BACKGROUND    = 24'h00_64_00,
   parameter logic [10:0] START_X       = 11'd64,
   parameter logic [10:0] START_Y       = 11'd128,
   parameter logic [10:0] LETTER_WIDTH  = 11'd64,
   parameter logic [10:0] LETTER_HEIGHT = 11'd128,
   parameter logic [10:0] LINE_WIDTH    = 11'd16,
   parameter logic [10:0] LETTER_SPACE  = 11'd32,
   parameter logic [10:0] WORD_SPACE    = 11'd64,
   parameter logic [10:0] SLIDE_DIST    = 11'd256,
   parameter logic [10:0] SLIDE_STEP    = 11'd16,
   parameter int          BLINK_FRAMES  = 8,
   parameter int          HOLD_FRAMES   = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [WINNER_W-1:0] winner,
   input  logic                frame_tick,
   input  logic [10:0]         hcount,
   input  logic [10:0]         vcount,
   output logic [23:0]         pixel,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLIDE = 2'd1,
      BLINK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FC_W = $clog2(HOLD_FRAMES + 1);
   localparam int BC_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [FC_W-1:0]     HOLD_LAST  = FC_W'(HOLD_FRAMES);
   localparam logic [BC_W-1:0]     BLINK_LAST = BC_W'(BLINK_FRAMES);
   localparam logic [WINNER_W-1:0] MAX_WIN    = WINNER_W'(NUM_PLAYERS - 1);

   // Glyph layout, all relative to each glyph's top-left corner
   localparam logic [10:0] PITCH      = LETTER_WIDTH + LETTER_SPACE;
   localparam logic [10:0] HALF_W     = LETTER_WIDTH >> 1;
   localparam logic [10:0] RIGHT_COL  = LETTER_WIDTH - LINE_WIDTH;
   localparam logic [10:0] BOTTOM_ROW = LETTER_HEIGHT - LINE_WIDTH;
   localparam logic [10:0] P_BOWL_H   = LETTER_HEIGHT >> 1;
   localparam logic [10:0] P_MID_Y    = P_BOWL_H - LINE_WIDTH;
   localparam logic [10:0] BANG_H     = 11'd80;
   localparam logic [10:0] NUM_X      = START_X + PITCH;
   localparam logic [10:0] W_X        = NUM_X + 11'(NUM_PLAYERS - 1) * LETTER_SPACE
                                        + LINE_WIDTH + WORD_SPACE;
   localparam logic [10:0] O_X        = W_X + PITCH;
   localparam logic [10:0] N_X        = O_X + PITCH;
   localparam logic [10:0] BANG_X     = N_X + PITCH;

   state_t              state_q, state_d;
   logic [10:0]         y_off_q, y_off_d;
   logic                visible_q, visible_d;
   logic [WINNER_W-1:0] win_idx_q, win_idx_d;
   logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic [10:0]         h1_q, h1_d, v1_q, v1_d, yoff1_q, yoff1_d;
   logic                vis1_q, vis1_d;
   logic [WINNER_W-1:0] win1_q, win1_d;
   logic [23:0]         pixel_q, pixel_d;

   logic [10:0]            ty;
   logic [NUM_PLAYERS-1:0] tally_hit;
   logic                   hit;

   // Inclusive rectangle test; 12-bit sums keep the right/bottom edges exact
   function automatic logic in_rect(input logic [10:0] h, input logic [10:0] v,
                                    input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] w, input logic [10:0] ht);
      return ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} <= {1'b0, x} + {1'b0, w}) &&
             ({1'b0, v} >= {1'b0, y}) && ({1'b0, v} <= {1'b0, y} + {1'b0, ht});
   endfunction

   always_comb begin
      state_d     = state_q;
      y_off_d     = y_off_q;
      visible_d   = visible_q;
      win_idx_d   = win_idx_q;
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               win_idx_d   = (winner > MAX_WIN) ? MAX_WIN : winner;
               y_off_d     = SLIDE_DIST;
               visible_d   = 1'b1;
               frame_cnt_d = '0;
               blink_cnt_d = '0;
               state_d     = SLIDE;
            end
         end
         SLIDE: begin
            if (frame_tick) begin
               if (y_off_q <= SLIDE_STEP) begin
                  y_off_d     = '0;
                  frame_cnt_d = '0;
                  blink_cnt_d = '0;
                  visible_d   = 1'b1;
                  state_d     = BLINK;
               end else begin
                  y_off_d = y_off_q - SLIDE_STEP;
               end
            end
         end
         BLINK: begin
            if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + FC_W'(1);
               blink_cnt_d = blink_cnt_q + BC_W'(1);
               if (blink_cnt_d == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  visible_d   = ~visible_q;
               end
               if (frame_cnt_d == HOLD_LAST) begin
                  visible_d = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_q == SLIDE) || (state_q == BLINK);
      done_d = (state_q == DONE);
   end

   assign ty = START_Y + yoff1_q;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_tally
      localparam logic [10:0]         BAR_X   = NUM_X + 11'(i) * LETTER_SPACE;
      localparam logic [WINNER_W-1:0] BAR_IDX = WINNER_W'(i);
      assign tally_hit[i] = (BAR_IDX <= win1_q) &&
                            in_rect(h1_q, v1_q, BAR_X, ty, LINE_WIDTH, LETTER_HEIGHT);
   end

   always_comb begin
      h1_d    = hcount;
      v1_d    = vcount;
      yoff1_d = y_off_q;
      vis1_d  = visible_q;
      win1_d  = win_idx_q;

      hit = |tally_hit;
      hit = hit | in_rect(h1_q, v1_q, START_X,             ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, START_X + LINE_WIDTH, ty,           HALF_W,       LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, START_X + LINE_WIDTH, ty + P_MID_Y, HALF_W,       LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, START_X + RIGHT_COL,  ty,           LINE_WIDTH,   P_BOWL_H);
      hit = hit | in_rect(h1_q, v1_q, W_X,                 ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, W_X + HALF_W,        ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, W_X + LETTER_WIDTH,  ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, W_X,                 ty + BOTTOM_ROW, LETTER_WIDTH, LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, O_X,                 ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, O_X + RIGHT_COL,     ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, O_X,                 ty,           LETTER_WIDTH, LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, O_X,                 ty + BOTTOM_ROW, LETTER_WIDTH, LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, N_X,                 ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, N_X + RIGHT_COL,     ty,           LINE_WIDTH,   LETTER_HEIGHT);
      hit = hit | in_rect(h1_q, v1_q, N_X,                 ty,           LETTER_WIDTH, LINE_WIDTH);
      hit = hit | in_rect(h1_q, v1_q, BANG_X,              ty,           LINE_WIDTH,   BANG_H);

      pixel_d = (hit && vis1_q && (state_q != IDLE)) ? TEXT_COLOR : BACKGROUND;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         y_off_q     <= '0;
         visible_q   <= 1'b0;
         win_idx_q   <= '0;
         frame_cnt_q <= '0;
         blink_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         h1_q        <= '0;
         v1_q        <= '0;
         yoff1_q     <= '0;
         vis1_q      <= 1'b0;
         win1_q      <= '0;
         pixel_q     <= '0;
      end else begin
         state_q     <= state_d;
         y_off_q     <= y_off_d;
         visible_q   <= visible_d;
         win_idx_q   <= win_idx_d;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         h1_q        <= h1_d;
         v1_q        <= v1_d;
         yoff1_q     <= yoff1_d;
         vis1_q      <= vis1_d;
         win1_q      <= win1_d;
         pixel_q     <= pixel_d;
      end
   end

   assign pixel = pixel_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
`default_nettype wire
